// File: rtl/raster_pkg.sv
// Shared rasterizer-setup types, screen limits and edge-coefficient helpers.
package raster_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int INV_FRAC = 24;

  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int Z_W    = 16;
  localparam int AB_W   = 9;
  localparam int C_W    = 18;
  localparam int AREA_W = 20;
  localparam int INV_W  = 32;
  localparam int QUOT_W = INV_FRAC + 1;

  localparam int AB_MIN = -256;
  localparam int AB_MAX = 255;
  localparam int C_MIN  = -131072;
  localparam int C_MAX  = 131071;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [Z_W-1:0] z;
  } vertex_t;

  // Full-precision edge terms; narrowed only after the range check.
  typedef struct packed {
    int a;
    int b;
    int c;
  } edge_t;

  typedef enum logic [2:0] {
    S_IDLE, S_AREA, S_ORIENT, S_COEF, S_CHECK, S_DIV, S_LAUNCH, S_WAIT
  } setup_state_t;

  function automatic edge_t edge_coef(input vertex_t p, input vertex_t q);
    edge_t e;
    e.a = int'(p.y) - int'(q.y);
    e.b = int'(q.x) - int'(p.x);
    e.c = int'(p.x) * int'(q.y) - int'(q.x) * int'(p.y);
    return e;
  endfunction

  function automatic logic out_of_range(input int v, input int lo, input int hi);
    return (v < lo) || (v > hi);
  endfunction
endpackage

// File: rtl/recip_div.sv
// Serial radix-2 restoring divider, one quotient bit per cycle, MSB first.
// The start cycle already resolves the top bit, so N bits take N edges.
module recip_div #(
  parameter int N  = 25,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [N-1:0]  i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic [N-1:0]  o_quotient
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  r_dividend, r_quot;
  logic [DW-1:0] r_divisor, r_rem;
  logic [IW-1:0] r_idx;
  logic          r_busy, r_done;

  logic [N-1:0]  w_dividend, w_quot_in, w_quot_nxt;
  logic [DW-1:0] w_divisor, w_rem_in, w_rem_nxt;
  logic [IW-1:0] w_idx;
  logic [DW:0]   w_shift;
  logic          w_ge;

  always_comb begin
    w_dividend = i_start ? i_dividend : r_dividend;
    w_divisor  = i_start ? i_divisor  : r_divisor;
    w_rem_in   = i_start ? '0 : r_rem;
    w_quot_in  = i_start ? '0 : r_quot;
    w_idx      = i_start ? IW'(N-1) : r_idx;
    w_shift    = {w_rem_in, w_dividend[w_idx]};
    w_ge       = (w_shift >= {1'b0, w_divisor});
    w_rem_nxt  = w_ge ? DW'(w_shift - {1'b0, w_divisor}) : w_shift[DW-1:0];
    w_quot_nxt = w_quot_in;
    w_quot_nxt[w_idx] = w_ge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_dividend <= i_dividend;
        r_divisor  <= i_divisor;
      end
      if (i_start || r_busy) begin
        r_rem  <= w_rem_nxt;
        r_quot <= w_quot_nxt;
        if (w_idx == '0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_busy <= 1'b1;
          r_idx  <= w_idx - 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quot;
endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: winding fix, edge coefficients, clipped bbox and 1/area,
// then hands a frozen parameter set to the rasterizer until it reports done.
module triangle_setup
  import raster_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tri_valid,
  output logic              tri_ready,
  input  logic [X_W-1:0]    x1,
  input  logic [X_W-1:0]    x2,
  input  logic [X_W-1:0]    x3,
  input  logic [Y_W-1:0]    y1,
  input  logic [Y_W-1:0]    y2,
  input  logic [Y_W-1:0]    y3,
  input  logic [Z_W-1:0]    z1_in,
  input  logic [Z_W-1:0]    z2_in,
  input  logic [Z_W-1:0]    z3_in,
  input  logic [7:0]        tri_color,
  output logic              tri_done,
  output logic              tri_rejected,
  output logic [AB_W-1:0]   a1,
  output logic [AB_W-1:0]   b1,
  output logic [AB_W-1:0]   a2,
  output logic [AB_W-1:0]   b2,
  output logic [AB_W-1:0]   a3,
  output logic [AB_W-1:0]   b3,
  output logic [C_W-1:0]    c1,
  output logic [C_W-1:0]    c2,
  output logic [C_W-1:0]    c3,
  output logic [X_W-1:0]    bbxi,
  output logic [X_W-1:0]    bbxf,
  output logic [Y_W-1:0]    bbyi,
  output logic [Y_W-1:0]    bbyf,
  output logic [Z_W-1:0]    z1,
  output logic [Z_W-1:0]    z2,
  output logic [Z_W-1:0]    z3,
  output logic [7:0]        color,
  output logic [INV_W-1:0]  inv_area,
  output logic              rasterizer_start,
  input  logic              rasterizer_done
);
  setup_state_t r_state;
  vertex_t      r_v1, r_v2, r_v3;
  logic [7:0]   r_col;
  logic signed [AREA_W-1:0] r_area2;
  logic         r_ready, r_done, r_rej, r_start, r_reject;

  logic [AB_W-1:0]  r_a1, r_b1, r_a2, r_b2, r_a3, r_b3;
  logic [C_W-1:0]   r_c1, r_c2, r_c3;
  logic [X_W-1:0]   r_bbxi, r_bbxf;
  logic [Y_W-1:0]   r_bbyi, r_bbyf;
  logic [Z_W-1:0]   r_z1, r_z2, r_z3;
  logic [7:0]       r_color;
  logic [INV_W-1:0] r_inv;

  edge_t            w_e1, w_e2, w_e3;
  logic signed [AREA_W-1:0] w_area;
  logic [X_W-1:0]   w_xmin, w_xmax;
  logic [Y_W-1:0]   w_ymin, w_ymax;
  logic             w_reject;
  logic             w_div_start, w_div_busy, w_div_done;
  logic [QUOT_W-1:0] w_quot;

  // Edge k is opposite vertex k, so it interpolates that vertex's depth.
  always_comb begin
    w_e1   = edge_coef(r_v2, r_v3);
    w_e2   = edge_coef(r_v3, r_v1);
    w_e3   = edge_coef(r_v1, r_v2);
    w_area = AREA_W'(w_e1.a * int'(r_v1.x) + w_e1.b * int'(r_v1.y) + w_e1.c);
  end

  always_comb begin
    w_xmin = (r_v1.x < r_v2.x) ? r_v1.x : r_v2.x;
    w_xmin = (r_v3.x < w_xmin) ? r_v3.x : w_xmin;
    w_xmax = (r_v1.x > r_v2.x) ? r_v1.x : r_v2.x;
    w_xmax = (r_v3.x > w_xmax) ? r_v3.x : w_xmax;
    w_ymin = (r_v1.y < r_v2.y) ? r_v1.y : r_v2.y;
    w_ymin = (r_v3.y < w_ymin) ? r_v3.y : w_ymin;
    w_ymax = (r_v1.y > r_v2.y) ? r_v1.y : r_v2.y;
    w_ymax = (r_v3.y > w_ymax) ? r_v3.y : w_ymax;
  end

  always_comb begin
    w_reject = (r_area2 == '0)
            || out_of_range(w_e1.a, AB_MIN, AB_MAX) || out_of_range(w_e1.b, AB_MIN, AB_MAX)
            || out_of_range(w_e2.a, AB_MIN, AB_MAX) || out_of_range(w_e2.b, AB_MIN, AB_MAX)
            || out_of_range(w_e3.a, AB_MIN, AB_MAX) || out_of_range(w_e3.b, AB_MIN, AB_MAX)
            || out_of_range(w_e1.c, C_MIN, C_MAX)
            || out_of_range(w_e2.c, C_MIN, C_MAX)
            || out_of_range(w_e3.c, C_MIN, C_MAX)
            || (int'(w_xmin) > SCREEN_W - 1)
            || (int'(w_ymin) > SCREEN_H - 1);
  end

  assign w_div_start = (r_state == S_CHECK) && !r_reject && !w_div_busy;

  recip_div #(.N(QUOT_W), .DW(AREA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_div_start),
    .i_dividend(QUOT_W'(1) << INV_FRAC),
    .i_divisor ($unsigned(r_area2)),
    .o_busy    (w_div_busy),
    .o_done    (w_div_done),
    .o_quotient(w_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_rej    <= 1'b0;
      r_start  <= 1'b0;
      r_reject <= 1'b0;
      r_v1     <= '0;
      r_v2     <= '0;
      r_v3     <= '0;
      r_col    <= '0;
      r_area2  <= '0;
      r_a1 <= '0; r_b1 <= '0; r_a2 <= '0; r_b2 <= '0; r_a3 <= '0; r_b3 <= '0;
      r_c1 <= '0; r_c2 <= '0; r_c3 <= '0;
      r_bbxi <= '0; r_bbxf <= '0; r_bbyi <= '0; r_bbyf <= '0;
      r_z1 <= '0; r_z2 <= '0; r_z3 <= '0;
      r_color <= '0;
      r_inv   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rej   <= 1'b0;
      r_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (tri_valid && r_ready) begin
            r_v1    <= '{x: x1, y: y1, z: z1_in};
            r_v2    <= '{x: x2, y: y2, z: z2_in};
            r_v3    <= '{x: x3, y: y3, z: z3_in};
            r_col   <= tri_color;
            r_ready <= 1'b0;
            r_state <= S_AREA;
          end
        end
        S_AREA: begin
          r_area2 <= w_area;
          r_state <= S_ORIENT;
        end
        S_ORIENT: begin
          if (r_area2 < 0) begin
            r_v2    <= r_v3;
            r_v3    <= r_v2;
            r_area2 <= -r_area2;
          end
          r_state <= S_COEF;
        end
        // Verdict is registered here so the reject pulse lands in the CHECK cycle.
        S_COEF: begin
          r_a1 <= w_e1.a[AB_W-1:0]; r_b1 <= w_e1.b[AB_W-1:0]; r_c1 <= w_e1.c[C_W-1:0];
          r_a2 <= w_e2.a[AB_W-1:0]; r_b2 <= w_e2.b[AB_W-1:0]; r_c2 <= w_e2.c[C_W-1:0];
          r_a3 <= w_e3.a[AB_W-1:0]; r_b3 <= w_e3.b[AB_W-1:0]; r_c3 <= w_e3.c[C_W-1:0];
          r_bbxi <= (int'(w_xmin) > SCREEN_W - 1) ? X_W'(SCREEN_W - 1) : w_xmin;
          r_bbxf <= (int'(w_xmax) > SCREEN_W - 1) ? X_W'(SCREEN_W - 1) : w_xmax;
          r_bbyi <= (int'(w_ymin) > SCREEN_H - 1) ? Y_W'(SCREEN_H - 1) : w_ymin;
          r_bbyf <= (int'(w_ymax) > SCREEN_H - 1) ? Y_W'(SCREEN_H - 1) : w_ymax;
          r_z1 <= r_v1.z;
          r_z2 <= r_v2.z;
          r_z3 <= r_v3.z;
          r_color  <= r_col;
          r_reject <= w_reject;
          r_done   <= w_reject;
          r_rej    <= w_reject;
          r_state  <= S_CHECK;
        end
        S_CHECK: begin
          if (r_reject) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_inv   <= {{(INV_W-QUOT_W){1'b0}}, w_quot};
            r_start <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (rasterizer_done) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Completion is reported in the same cycle the rasterizer signals done.
  assign tri_done         = r_done | ((r_state == S_WAIT) && rasterizer_done);
  assign tri_rejected     = r_rej;
  assign tri_ready        = r_ready;
  assign rasterizer_start = r_start;

  assign a1 = r_a1; assign b1 = r_b1; assign c1 = r_c1;
  assign a2 = r_a2; assign b2 = r_b2; assign c2 = r_c2;
  assign a3 = r_a3; assign b3 = r_b3; assign c3 = r_c3;
  assign bbxi = r_bbxi; assign bbxf = r_bbxf;
  assign bbyi = r_bbyi; assign bbyf = r_bbyf;
  assign z1 = r_z1; assign z2 = r_z2; assign z3 = r_z3;
  assign color    = r_color;
  assign inv_area = r_inv;
endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: latency, coefficients, rejects, reset and hold-off.
module tb_triangle_setup;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  logic [8:0]  x1 = '0, x2 = '0, x3 = '0;
  logic [7:0]  y1 = '0, y2 = '0, y3 = '0;
  logic [15:0] z1_in = '0, z2_in = '0, z3_in = '0;
  logic [7:0]  tri_color = '0;
  logic        tri_done, tri_rejected;
  logic [8:0]  a1, b1, a2, b2, a3, b3;
  logic [17:0] c1, c2, c3;
  logic [8:0]  bbxi, bbxf;
  logic [7:0]  bbyi, bbyf;
  logic [15:0] z1, z2, z3;
  logic [7:0]  color;
  logic [31:0] inv_area;
  logic        rasterizer_start;
  logic        rasterizer_done = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  triangle_setup dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2), .y3(y3),
    .z1_in(z1_in), .z2_in(z2_in), .z3_in(z3_in), .tri_color(tri_color),
    .tri_done(tri_done), .tri_rejected(tri_rejected),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
    .c1(c1), .c2(c2), .c3(c3),
    .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
    .z1(z1), .z2(z2), .z3(z3), .color(color), .inv_area(inv_area),
    .rasterizer_start(rasterizer_start), .rasterizer_done(rasterizer_done)
  );

  always #5 clk = ~clk;

  wire [229:0] w_outs = {a1, b1, a2, b2, a3, b3, c1, c2, c3, bbxi, bbxf, bbyi, bbyf,
                         z1, z2, z3, color, inv_area};

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [8:0] ax, input logic [7:0] ay, input logic [15:0] az,
                      input logic [8:0] bx, input logic [7:0] by, input logic [15:0] bz,
                      input logic [8:0] cx, input logic [7:0] cy, input logic [15:0] cz,
                      input logic [7:0] col, input bit hold);
    @(posedge clk); #1;
    x1 = ax; y1 = ay; z1_in = az;
    x2 = bx; y2 = by; z2_in = bz;
    x3 = cx; y3 = cy; z3_in = cz;
    tri_color = col;
    tri_valid = 1'b1;
    @(negedge clk);
    chk("ready_before_accept", tri_ready, 1);
    @(posedge clk); #1;
    if (!hold) tri_valid = 1'b0;
  endtask

  // Cycle k is observed k edges after the accept edge.
  task automatic run(input int ncyc, output int st_cyc, output int n_st,
                     output int dn_cyc, output int rj_cyc);
    st_cyc = 0; n_st = 0; dn_cyc = 0; rj_cyc = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (rasterizer_start) begin
        n_st++;
        if (st_cyc == 0) st_cyc = k;
      end
      if (tri_done && dn_cyc == 0) dn_cyc = k;
      if (tri_rejected && rj_cyc == 0) rj_cyc = k;
    end
  endtask

  task automatic finish_tri();
    @(posedge clk); #1;
    rasterizer_done = 1'b1;
    @(negedge clk);
    chk("tri_done_on_rdone", tri_done, 1);
    chk("no_reject_on_draw", tri_rejected, 0);
    @(posedge clk); #1;
    rasterizer_done = 1'b0;
    tri_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_done", tri_ready, 1);
    chk("tri_done_cleared", tri_done, 0);
  endtask

  task automatic chk_t1();
    chk("a1", $signed(a1), -10); chk("b1", $signed(b1), -10); chk("c1", $signed(c1), 300);
    chk("a2", $signed(a2), 10);  chk("b2", $signed(b2), 0);   chk("c2", $signed(c2), -100);
    chk("a3", $signed(a3), 0);   chk("b3", $signed(b3), 10);  chk("c3", $signed(c3), -100);
    chk("inv_area", inv_area, 167772);
  endtask

  initial begin
    int st, ns, dn, rj, n_rdy, n_chg;
    logic [229:0] snap;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_ready", tri_ready, 0);
    chk("rst_done", tri_done, 0);
    chk("rst_start", rasterizer_start, 0);
    chk("rst_inv", inv_area, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_release", tri_ready, 0);
    @(negedge clk);
    chk("ready_first_cycle", tri_ready, 1);

    // T1
    send(9'd10, 8'd10, 16'd100, 9'd20, 8'd10, 16'd200, 9'd10, 8'd20, 16'd300, 8'h3C, 1'b0);
    run(32, st, ns, dn, rj);
    chk("t1_start_cycle", st, 30);
    chk("t1_start_count", ns, 1);
    chk("t1_no_early_done", dn, 0);
    chk_t1();
    chk("t1_bbxi", bbxi, 10); chk("t1_bbxf", bbxf, 20);
    chk("t1_bbyi", bbyi, 10); chk("t1_bbyf", bbyf, 20);
    chk("t1_color", color, 8'h3C);
    chk("t1_z1", z1, 100); chk("t1_z2", z2, 200); chk("t1_z3", z3, 300);
    finish_tri();

    // T2: clockwise order gets swapped back
    send(9'd10, 8'd10, 16'd7, 9'd10, 8'd20, 16'd5, 9'd20, 8'd10, 16'd9, 8'h11, 1'b0);
    run(32, st, ns, dn, rj);
    chk("t2_start_cycle", st, 30);
    chk_t1();
    chk("t2_z1", z1, 7); chk("t2_z2", z2, 9); chk("t2_z3", z3, 5);
    finish_tri();

    // T3: collinear
    send(9'd0, 8'd0, 16'd1, 9'd5, 8'd5, 16'd2, 9'd10, 8'd10, 16'd3, 8'h01, 1'b0);
    run(5, st, ns, dn, rj);
    chk("t3_done_cycle", dn, 4);
    chk("t3_rej_cycle", rj, 4);
    chk("t3_ready_back", tri_ready, 1);
    run(30, st, ns, dn, rj);
    chk("t3_no_start", ns, 0);

    // T4a: coefficient overflow
    send(9'd0, 8'd0, 16'd1, 9'd300, 8'd0, 16'd2, 9'd0, 8'd10, 16'd3, 8'h02, 1'b0);
    run(40, st, ns, dn, rj);
    chk("t4a_rej_cycle", rj, 4);
    chk("t4a_no_start", ns, 0);

    // T4 boundary: bbox entirely right of the screen
    send(9'd330, 8'd10, 16'd1, 9'd340, 8'd10, 16'd2, 9'd330, 8'd20, 16'd3, 8'h03, 1'b0);
    run(40, st, ns, dn, rj);
    chk("offscreen_rej_cycle", rj, 4);
    chk("offscreen_no_start", ns, 0);

    // T4b: clamped bbox
    send(9'd300, 8'd200, 16'd1, 9'd400, 8'd200, 16'd2, 9'd300, 8'd230, 16'd3, 8'h04, 1'b0);
    run(32, st, ns, dn, rj);
    chk("t4b_start_cycle", st, 30);
    chk("t4b_bbxi", bbxi, 300); chk("t4b_bbxf", bbxf, 319);
    chk("t4b_bbyi", bbyi, 200); chk("t4b_bbyf", bbyf, 230);
    chk("t4b_c1", $signed(c1), 32000);
    chk("t4b_c2", $signed(c2), -9000);
    chk("t4b_c3", $signed(c3), -20000);
    chk("t4b_inv", inv_area, 5592);
    finish_tri();

    // T5: reset during DIV
    send(9'd10, 8'd10, 16'd100, 9'd20, 8'd10, 16'd200, 9'd10, 8'd20, 16'd300, 8'h3C, 1'b0);
    run(10, st, ns, dn, rj);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready", tri_ready, 0);
    chk("t5_rst_a1", $signed(a1), 0);
    chk("t5_rst_done", tri_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(9'd10, 8'd10, 16'd100, 9'd20, 8'd10, 16'd200, 9'd10, 8'd20, 16'd300, 8'h3C, 1'b0);
    run(32, st, ns, dn, rj);
    chk("t5_no_stale_done", dn, 0);
    chk("t5_start_cycle", st, 30);
    chk_t1();
    finish_tri();

    // T6: valid held high, stray done during DIV, late real done
    send(9'd10, 8'd10, 16'd100, 9'd20, 8'd10, 16'd200, 9'd10, 8'd20, 16'd300, 8'h3C, 1'b1);
    n_rdy = 0; n_chg = 0; ns = 0; st = 0; snap = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (tri_ready) n_rdy++;
      if (rasterizer_start) begin
        ns++;
        if (st == 0) st = k;
      end
      if (k == 9) rasterizer_done = 1'b1;
      if (k == 10) begin
        chk("t6_stray_rdone_ignored", tri_done, 0);
        rasterizer_done = 1'b0;
      end
      if (k == 31) snap = w_outs;
      if (k > 31 && w_outs !== snap) n_chg++;
    end
    chk("t6_start_cycle", st, 30);
    chk("t6_one_start", ns, 1);
    chk("t6_ready_low", n_rdy, 0);
    chk("t6_outputs_stable", n_chg, 0);
    chk_t1();
    finish_tri();
    @(negedge clk);
    chk("t6_no_second_accept", tri_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
